// File: rtl/sprite_frame_sequencer_if.sv
// Command bus between the frame sequencer and one 16x16 sprite control stage.
// Carries the draw/clear/shift_h/load strobes, the position to load, and the
// stage's pointer-is-zero flag coming back. Sequencer = master, stage = slave.
interface sprite_frame_sequencer_if;
    logic       draw;
    logic       clear;
    logic       shift_h;
    logic       load;
    logic [7:0] load_x;
    logic [6:0] load_y;
    logic       complete;

    modport master (
        output draw, clear, shift_h, load, load_x, load_y,
        input  complete
    );

    modport slave (
        input  draw, clear, shift_h, load, load_x, load_y,
        output complete
    );
endinterface

// File: rtl/sprite_frame_sequencer.sv
// Purpose: per-frame erase / reposition / redraw sequencer for one sprite stage.
// Latency: first frame done 258 cycles after the tick, later frames 514 cycles.
// Backpressure: none; ticks that cannot be taken are dropped and flagged in overrun.
// Ports: clk, resetn (async, active low); enable/frame_tick control the frame start;
//        spr carries the sprite stage command bus; busy/frame_done/overrun report status.
module sprite_frame_sequencer #(
    parameter int X_INIT = 80,
    parameter int Y_INIT = 60,
    parameter int X_MAX  = 144,
    parameter int Y_MAX  = 104,
    parameter int STEP   = 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            enable,
    input  logic                            frame_tick,
    sprite_frame_sequencer_if.master        spr,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            overrun
);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [7:0] X_INIT_V = 8'(X_INIT);
    localparam logic [6:0] Y_INIT_V = 7'(Y_INIT);
    localparam logic [8:0] X_MAX_W  = 9'(X_MAX);
    localparam logic [7:0] Y_MAX_W  = 8'(Y_MAX);
    localparam logic [7:0] X_MAX_V  = 8'(X_MAX);
    localparam logic [6:0] Y_MAX_V  = 7'(Y_MAX);
    localparam logic [8:0] STEP_X9  = 9'(STEP);
    localparam logic [7:0] STEP_X8  = 8'(STEP);
    localparam logic [7:0] STEP_Y8  = 8'(STEP);
    localparam logic [6:0] STEP_Y7  = 7'(STEP);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic       drawn_q, drawn_d;

    // Command outputs are registered so the stage sees them stable at its negedge sample.
    logic draw_q, draw_d;
    logic clear_q, clear_d;
    logic shift_q, shift_d;
    logic load_q, load_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic ovr_q, ovr_d;

    // Bounce arithmetic, one bit wider than the position so the limit test cannot wrap.
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic [7:0] x_new;
    logic [6:0] y_new;
    logic       dx_new, dy_new;

    always_comb begin
        x_sum  = {1'b0, x_q} + STEP_X9;
        y_sum  = {1'b0, y_q} + STEP_Y8;
        x_new  = x_q;
        y_new  = y_q;
        dx_new = dx_q;
        dy_new = dy_q;

        if (!dx_q) begin
            if (x_sum > X_MAX_W) begin
                x_new  = X_MAX_V;
                dx_new = 1'b1;
            end else begin
                x_new = x_sum[7:0];
            end
        end else begin
            if (x_q < STEP_X8) begin
                x_new  = 8'd0;
                dx_new = 1'b0;
            end else begin
                x_new = x_q - STEP_X8;
            end
        end

        if (!dy_q) begin
            if (y_sum > Y_MAX_W) begin
                y_new  = Y_MAX_V;
                dy_new = 1'b1;
            end else begin
                y_new = y_sum[6:0];
            end
        end else begin
            if (y_q < STEP_Y7) begin
                y_new  = 7'd0;
                dy_new = 1'b0;
            end else begin
                y_new = y_q - STEP_Y7;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        drawn_d = drawn_q;
        draw_d  = 1'b0;
        clear_d = 1'b0;
        shift_d = 1'b0;
        load_d  = 1'b0;
        done_d  = 1'b0;
        // Any tick the IDLE state cannot accept is a missed frame.
        ovr_d   = ovr_q | (frame_tick & ((state_q != S_IDLE) | ~enable));

        unique case (state_q)
            S_RESYNC: begin
                // Keep erasing until the stage's pointer wraps back to zero.
                if (spr.complete) begin
                    state_d = S_IDLE;
                end else begin
                    draw_d  = 1'b1;
                    clear_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (frame_tick && enable) begin
                    cnt_d  = 8'd0;
                    draw_d = 1'b1;
                    if (drawn_q) begin
                        state_d = S_CLEAR;
                        clear_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        load_d  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                draw_d = 1'b1;
                if (cnt_q == 8'd255) begin
                    state_d = S_LOAD;
                    load_d  = 1'b1;
                    x_d     = x_new;
                    y_d     = y_new;
                    dx_d    = dx_new;
                    dy_d    = dy_new;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    clear_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_DRAW;
                cnt_d   = 8'd0;
                draw_d  = 1'b1;
                shift_d = 1'b1;
            end
            S_DRAW: begin
                if (cnt_q == 8'd255) begin
                    state_d = S_DONE;
                    drawn_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    draw_d  = 1'b1;
                    shift_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_RESYNC;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_RESYNC;
            cnt_q   <= 8'd0;
            x_q     <= X_INIT_V;
            y_q     <= Y_INIT_V;
            dx_q    <= 1'b0;
            dy_q    <= 1'b0;
            drawn_q <= 1'b0;
            draw_q  <= 1'b0;
            clear_q <= 1'b0;
            shift_q <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            drawn_q <= drawn_d;
            draw_q  <= draw_d;
            clear_q <= clear_d;
            shift_q <= shift_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign spr.draw    = draw_q;
    assign spr.clear   = clear_q;
    assign spr.shift_h = shift_q;
    assign spr.load    = load_q;
    assign spr.load_x  = x_q;
    assign spr.load_y  = y_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Bench for sprite_frame_sequencer: instance A uses default parameters, instance B
// is set up to bounce on both axes. Each instance drives a small sprite stage model
// whose pointer advances on every non-load draw and reports complete at zero.
module tb_sprite_frame_sequencer;

    typedef struct {
        int inj_rel;   // relative cycle to inject an extra tick (0 = none)
        int drop_rel;  // relative cycle to drop enable (0 = none)
        int x;
        int y;
        int clr;       // expected clear cycles
        int ld_rel;    // expected load cycle
        int done_rel;  // expected frame_done cycle
        int ovr;       // expected overrun after the frame
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rstn;
    logic [1:0] tick;
    logic [1:0] en;
    logic [1:0] busy, fdone, ovr;

    sprite_frame_sequencer_if s_a();
    sprite_frame_sequencer_if s_b();

    sprite_frame_sequencer dut_a (
        .clk(clk), .resetn(rstn[0]), .enable(en[0]), .frame_tick(tick[0]),
        .spr(s_a), .busy(busy[0]), .frame_done(fdone[0]), .overrun(ovr[0])
    );

    sprite_frame_sequencer #(
        .X_INIT(143), .Y_INIT(0), .X_MAX(144), .Y_MAX(1), .STEP(2)
    ) dut_b (
        .clk(clk), .resetn(rstn[1]), .enable(en[1]), .frame_tick(tick[1]),
        .spr(s_b), .busy(busy[1]), .frame_done(fdone[1]), .overrun(ovr[1])
    );

    logic [1:0] m_draw, m_clear, m_shift, m_load;
    logic [7:0] m_x [2];
    logic [6:0] m_y [2];
    assign m_draw  = {s_b.draw,    s_a.draw};
    assign m_clear = {s_b.clear,   s_a.clear};
    assign m_shift = {s_b.shift_h, s_a.shift_h};
    assign m_load  = {s_b.load,    s_a.load};
    assign m_x[0]  = s_a.load_x;
    assign m_x[1]  = s_b.load_x;
    assign m_y[0]  = s_a.load_y;
    assign m_y[1]  = s_b.load_y;

    // Sprite stage model: no reset, pointer samples on negedge.
    logic [7:0] ptr [2] = '{8'd0, 8'd0};
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            if (m_draw[i] && !m_load[i]) ptr[i] <= ptr[i] + 8'd1;
    end
    assign s_a.complete = (ptr[0] == 8'd0);
    assign s_b.complete = (ptr[1] == 8'd0);

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: runner pushes expectations, monitor pops on frame_done.
    frame_t sb_a[$];
    frame_t sb_b[$];
    int e0 [2]       = '{0, 0};
    int frame_id [2] = '{0, 0};
    int seen_id [2]  = '{0, 0};
    int done_cnt [2] = '{0, 0};
    bit act [2]      = '{1'b0, 1'b0};
    int clr_n [2], drw_n [2], ld_n [2], ld_rel [2], ld_x [2], ld_y [2];
    int fr_n [2]     = '{0, 0};
    int onehot_err   = 0;

    always @(negedge clk) begin
        int rel;
        frame_t f;
        bit have;
        for (int i = 0; i < 2; i++) begin
            if (m_draw[i] && (int'(m_clear[i]) + int'(m_shift[i]) + int'(m_load[i]) != 1))
                onehot_err++;
            if (frame_id[i] != seen_id[i]) begin
                seen_id[i] = frame_id[i];
                act[i]   = 1'b1;
                clr_n[i] = 0;
                drw_n[i] = 0;
                ld_n[i]  = 0;
                ld_rel[i] = -1;
                ld_x[i]  = -1;
                ld_y[i]  = -1;
            end
            if (act[i]) begin
                rel = edge_cnt - e0[i] + 1;
                if (m_draw[i] && m_clear[i]) clr_n[i]++;
                if (m_draw[i] && m_shift[i]) drw_n[i]++;
                if (m_load[i]) begin
                    ld_n[i]++;
                    ld_rel[i] = rel;
                    ld_x[i]   = int'(m_x[i]);
                    ld_y[i]   = int'(m_y[i]);
                end
                if (fdone[i]) begin
                    have = 1'b0;
                    if (i == 0 && sb_a.size() > 0) begin f = sb_a.pop_front(); have = 1'b1; end
                    if (i == 1 && sb_b.size() > 0) begin f = sb_b.pop_front(); have = 1'b1; end
                    if (!have) begin
                        check($sformatf("u%0d_scoreboard_empty", i), 0, 1);
                    end else begin
                        check($sformatf("u%0d_f%0d_clear_cycles", i, fr_n[i]), clr_n[i], f.clr);
                        check($sformatf("u%0d_f%0d_draw_cycles", i, fr_n[i]), drw_n[i], 256);
                        check($sformatf("u%0d_f%0d_load_pulses", i, fr_n[i]), ld_n[i], 1);
                        check($sformatf("u%0d_f%0d_load_cycle", i, fr_n[i]), ld_rel[i], f.ld_rel);
                        check($sformatf("u%0d_f%0d_load_x", i, fr_n[i]), ld_x[i], f.x);
                        check($sformatf("u%0d_f%0d_load_y", i, fr_n[i]), ld_y[i], f.y);
                        check($sformatf("u%0d_f%0d_done_cycle", i, fr_n[i]), rel, f.done_rel);
                    end
                    fr_n[i]++;
                    act[i] = 1'b0;
                    done_cnt[i] <= done_cnt[i] + 1;
                end
            end
        end
    end

    task automatic run_frame(input int i, input frame_t f);
        int start_done;
        int rel;
        bit got;
        if (i == 0) sb_a.push_back(f); else sb_b.push_back(f);
        start_done = done_cnt[i];
        @(negedge clk);
        tick[i] = 1'b1;
        e0[i] = edge_cnt + 1;
        frame_id[i] = frame_id[i] + 1;
        got = 1'b0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            rel = edge_cnt - e0[i] + 1;
            tick[i] = (f.inj_rel != 0 && rel == f.inj_rel);
            if (f.drop_rel != 0 && rel == f.drop_rel) en[i] = 1'b0;
            if (done_cnt[i] != start_done && rel > f.inj_rel) begin
                got = 1'b1;
                break;
            end
        end
        tick[i] = 1'b0;
        en[i] = 1'b1;
        if (!got) check($sformatf("u%0d_frame_timeout", i), 0, 1);
        check($sformatf("u%0d_overrun_after_frame", i), int'(ovr[i]), f.ovr);
        repeat (3) @(negedge clk);
        check($sformatf("u%0d_idle_after_frame", i), int'(busy[i]), 0);
    endtask

    frame_t tab_a [5];
    frame_t tab_b [4];

    initial begin
        int n;
        bit found;

        //             inj  drop  x    y   clr  ld   done ovr
        tab_a[0] = '{  0,    0,  80,  60,   0,   1, 258, 0};
        tab_a[1] = '{  0,  100,  81,  61, 256, 257, 514, 0};
        tab_a[2] = '{  0,    0,  82,  62, 256, 257, 514, 1};
        tab_a[3] = '{200,    0,  80,  60,   0,   1, 258, 1};
        tab_a[4] = '{  0,    0,  81,  61, 256, 257, 514, 1};
        tab_b[0] = '{  0,    0, 143,   0,   0,   1, 258, 0};
        tab_b[1] = '{  0,    0, 144,   1, 256, 257, 514, 0};
        tab_b[2] = '{  0,    0, 142,   0, 256, 257, 514, 0};
        tab_b[3] = '{514,    0, 140,   1, 256, 257, 514, 1};

        rstn = 2'b00;
        tick = 2'b00;
        en   = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_draw",    int'(s_a.draw), 0);
        check("rst_clear",   int'(s_a.clear), 0);
        check("rst_shift_h", int'(s_a.shift_h), 0);
        check("rst_load",    int'(s_a.load), 0);
        check("rst_done",    int'(fdone[0]), 0);
        check("rst_overrun", int'(ovr[0]), 0);
        check("rst_busy",    int'(busy[0]), 1);
        check("rst_load_x",  int'(s_a.load_x), 80);
        check("rst_load_y",  int'(s_a.load_y), 60);
        check("rst_b_load_x", int'(s_b.load_x), 143);
        check("rst_b_load_y", int'(s_b.load_y), 0);
        rstn = 2'b11;
        @(negedge clk);
        check("resync_exit_busy", int'(busy[0]), 0);
        check("resync_exit_draw", int'(s_a.draw), 0);

        run_frame(0, tab_a[0]);
        run_frame(0, tab_a[1]);

        // Tick while disabled in IDLE: flagged, not accepted.
        @(negedge clk);
        en[0] = 1'b0;
        tick[0] = 1'b1;
        @(negedge clk);
        tick[0] = 1'b0;
        check("disabled_tick_overrun", int'(ovr[0]), 1);
        repeat (3) @(negedge clk);
        check("disabled_tick_busy", int'(busy[0]), 0);
        en[0] = 1'b1;

        run_frame(0, tab_a[2]);

        // Start a frame and reset it mid-DRAW once the stage pointer reaches 100.
        @(negedge clk);
        tick[0] = 1'b1;
        @(negedge clk);
        tick[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #2;
            if (s_a.draw && s_a.shift_h && ptr[0] == 8'd100) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_draw_point_reached", int'(found), 1);
        rstn[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy",    int'(busy[0]), 1);
        check("midrst_draw",    int'(s_a.draw), 0);
        check("midrst_overrun", int'(ovr[0]), 0);
        check("midrst_load_x",  int'(s_a.load_x), 80);
        rstn[0] = 1'b1;
        n = 0;
        for (int k = 0; k < 400 && busy[0]; k++) begin
            @(negedge clk);
            if (s_a.draw && s_a.clear) n++;
        end
        check("resync_clear_cycles", n, 156);
        check("resync_idle", int'(busy[0]), 0);
        check("resync_load_y", int'(s_a.load_y), 60);

        run_frame(0, tab_a[3]);
        run_frame(0, tab_a[4]);

        for (int k = 0; k < 4; k++) run_frame(1, tab_b[k]);

        check("draw_onehot_violations", onehot_err, 0);
        check("scoreboard_drained", sb_a.size() + sb_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
